// File: rtl/fir_mac_engine.sv
// Sequential FIR filter: one tap per cycle through an external combinational multiplier.
// Sample in, TAPS multiply-accumulate cycles, then the result is held until the consumer takes it.
module fir_mac_engine #(
  parameter int OPERAND_SIZE = 8,
  parameter int TAPS         = 8,
  parameter int ACC_WIDTH    = 2 * OPERAND_SIZE + $clog2(TAPS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPERAND_SIZE-1:0]   in_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [OPERAND_SIZE-1:0]   coef_data,
  output logic [OPERAND_SIZE-1:0]   mult_md,
  output logic [OPERAND_SIZE-1:0]   mult_mr,
  input  logic [2*OPERAND_SIZE-1:0] mult_product,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic                      busy
);

  localparam int IDX_W  = $clog2(TAPS);
  localparam int PROD_W = 2 * OPERAND_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [IDX_W-1:0]        idx_r;
  logic [ACC_WIDTH-1:0]    acc_r;
  logic [ACC_WIDTH-1:0]    prod_ext_s;
  logic [ACC_WIDTH-1:0]    acc_sum_s;
  logic [OPERAND_SIZE-1:0] x_r [TAPS];
  logic [OPERAND_SIZE-1:0] c_r [TAPS];
  logic                    accept_s;
  logic                    last_s;
  logic                    coef_wr_s;

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign last_s    = (idx_r == IDX_W'(TAPS - 1));
  assign coef_wr_s = coef_we && (state_r == IDLE);

  // Product is sign-extended so the accumulator sum stays two's complement.
  assign prod_ext_s = {{(ACC_WIDTH - PROD_W){mult_product[PROD_W-1]}}, mult_product};
  assign acc_sum_s  = acc_r + prod_ext_s;

  // Next-state decode and multiplier operand steering.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    mult_md  = '0;
    mult_mr  = '0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          state_s  = MAC;
        end else begin
          state_s  = IDLE;
        end
      end
      MAC: begin
        mult_md = x_r[idx_r];
        mult_mr = c_r[idx_r];
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = MAC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Tap index and accumulator; the index wraps to zero after the last tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= '0;
      acc_r <= '0;
    end else if (accept_s) begin
      idx_r <= '0;
      acc_r <= '0;
    end else if (state_r == MAC) begin
      acc_r <= acc_sum_s;
      if (last_s) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end else begin
      idx_r <= idx_r;
      acc_r <= acc_r;
    end
  end

  // Sample delay line, shifted only when a sample is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        x_r[k] <= '0;
      end
    end else if (accept_s) begin
      for (int k = TAPS - 1; k > 0; k--) begin
        x_r[k] <= x_r[k-1];
      end
      x_r[0] <= in_data;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        x_r[k] <= x_r[k];
      end
    end
  end

  // Coefficient file; writes are only honoured while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        c_r[k] <= '0;
      end
    end else if (coef_wr_s) begin
      c_r[coef_addr] <= coef_data;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        c_r[k] <= c_r[k];
      end
    end
  end

  // Result register; held stable for the whole DONE state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if ((state_r == MAC) && last_s) begin
      out_valid <= 1'b1;
      out_data  <= acc_sum_s;
    end else if ((state_r == DONE) && out_ready) begin
      out_valid <= 1'b0;
      out_data  <= out_data;
    end else begin
      out_valid <= out_valid;
      out_data  <= out_data;
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine: table of sample/result vectors plus hand-written
// sequences for backpressure, busy coefficient writes and mid-computation reset.
module tb_fir_mac_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = 3'd0;
  logic [7:0]  coef_data = 8'd0;
  logic [7:0]  mult_md;
  logic [7:0]  mult_mr;
  logic [15:0] mult_product;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [18:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit first;
    int cset;
    int sample;
    int expected;
  } vec_t;

  vec_t vecs[19];
  int   cs[3][8];

  fir_mac_engine dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .mult_md(mult_md), .mult_mr(mult_mr), .mult_product(mult_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  // Stand-in for the external combinational Booth multiplier.
  assign mult_product = $signed(mult_md) * $signed(mult_mr);

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_mult_md", int'(mult_md), 0);
    check("rst_mult_mr", int'(mult_mr), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", int'(in_ready), 1);
  endtask

  task automatic write_coef(input int addr, input int val);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'(addr); coef_data = 8'(val);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic load_coefs(input int set);
    for (int k = 0; k < 8; k++) begin
      write_coef(k, cs[set][k]);
    end
  endtask

  // Offer one sample, measure latency, check the result, optionally stall, then consume.
  task automatic send(input int sample, input int exp, input int hold,
                      input bit wr_mac, input bit wr_acc, input int wr_val);
    int n;
    @(negedge clk);
    check("ready_idle", int'(in_ready), 1);
    in_data = 8'(sample); in_valid = 1'b1;
    if (wr_acc) begin
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'(wr_val);
    end
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0;
    check("mac_busy", int'(busy), 1);
    check("mac_in_ready", int'(in_ready), 0);
    check("mac_md_tap0", int'($signed(mult_md)), sample);
    if (wr_mac) begin
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'd5;
    end
    while (!out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      coef_we = 1'b0;
    end
    check("latency", n, 9);
    check("out_valid", int'(out_valid), 1);
    check("out_data", int'($signed(out_data)), exp);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_data = 8'd99;
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", int'(out_valid), 1);
      check("hold_data", int'($signed(out_data)), exp);
      check("hold_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", int'(out_valid), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_md", int'(mult_md), 0);
  endtask

  initial begin
    cs[0] = '{1, 2, 3, 4, 5, 6, 7, 8};
    cs[1] = '{-128, -128, -128, -128, -128, -128, -128, -128};
    cs[2] = '{127, -128, 1, 0, 0, 0, 0, 0};

    vecs[0]  = '{1'b1, 0, 1, 1};
    vecs[1]  = '{1'b0, 0, 0, 2};
    vecs[2]  = '{1'b0, 0, 0, 3};
    vecs[3]  = '{1'b0, 0, 0, 4};
    vecs[4]  = '{1'b0, 0, 0, 5};
    vecs[5]  = '{1'b0, 0, 0, 6};
    vecs[6]  = '{1'b0, 0, 0, 7};
    vecs[7]  = '{1'b0, 0, 0, 8};
    vecs[8]  = '{1'b1, 1, -128, 16384};
    vecs[9]  = '{1'b0, 1, -128, 32768};
    vecs[10] = '{1'b0, 1, -128, 49152};
    vecs[11] = '{1'b0, 1, -128, 65536};
    vecs[12] = '{1'b0, 1, -128, 81920};
    vecs[13] = '{1'b0, 1, -128, 98304};
    vecs[14] = '{1'b0, 1, -128, 114688};
    vecs[15] = '{1'b0, 1, -128, 131072};
    vecs[16] = '{1'b1, 2, 127, 16129};
    vecs[17] = '{1'b0, 2, -128, -32512};
    vecs[18] = '{1'b0, 2, 5, 17146};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].first) begin
        do_reset();
        load_coefs(vecs[i].cset);
      end
      send(vecs[i].sample, vecs[i].expected, 0, 1'b0, 1'b0, 0);
    end

    // Backpressure: stalled result stays put and offered samples are ignored.
    do_reset();
    load_coefs(0);
    send(7, 7, 5, 1'b0, 1'b0, 0);
    send(0, 14, 0, 1'b0, 1'b0, 0);

    // Coefficient write while busy is dropped.
    do_reset();
    load_coefs(0);
    send(10, 10, 0, 1'b1, 1'b0, 0);
    send(0, 20, 0, 1'b0, 1'b0, 0);
    send(1, 31, 0, 1'b0, 1'b0, 0);

    // Reset in the fourth MAC cycle aborts the computation.
    do_reset();
    write_coef(0, 2);
    @(negedge clk);
    in_data = 8'd9; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_data", int'(out_data), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_mult_md", int'(mult_md), 0);
    check("abort_mult_mr", int'(mult_mr), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready", int'(in_ready), 1);
    repeat (12) @(negedge clk);
    check("abort_no_result", int'(out_valid), 0);
    check("abort_idle", int'(busy), 0);
    // Coefficient write and sample acceptance in the same idle cycle.
    send(3, 6, 0, 1'b0, 1'b1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
